axi_lite_master: RTL and testbench

Single-outstanding AXI4-Lite master that turns a one-cycle `start_write` or `start_read` request into a complete bus transaction. It reports completion with a one-cycle `done` pulse and returns read data on `read_data`. It sits between simple control logic (sequencers, test drivers) and AXI4-Lite slaves such as the `axi_cfg_regs` configuration register file.

---
 rtl/axi_lite_pkg.sv | 25 ++
 rtl/axi_lite_master.sv | 174 +++++++++++++++++
 tb/tb_axi_lite_master.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared AXI4-Lite definitions: default bus widths, response codes and the
// master's transaction state encoding.
// ---------------------------------------------------------------------------
package axi_lite_pkg;

  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R
  } state_t;

endpackage

// File: rtl/axi_lite_master.sv
// ---------------------------------------------------------------------------
// axi_lite_master
// Single-outstanding AXI4-Lite master. A one-cycle start_write or start_read
// request is turned into a complete bus transaction; completion is signalled
// by a one-cycle done pulse and read results appear on read_data.
//
// Ports:
//   M_AXI_ACLK, M_AXI_ARESET   clock, synchronous active-high reset
//   addr, write_data           request address/payload, sampled on start
//   start_read, start_write    request pulses (write wins if both)
//   M_AXI_AW*/W*/B*            write address, data and response channels
//   M_AXI_AR*/R*               read address and data channels
//   done                       one-cycle completion pulse
//   read_data                  last read result, held until next read
// ---------------------------------------------------------------------------
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned C_M_AXI_ACLK_FREQ_HZ = 100000000,
  parameter int unsigned C_M_AXI_DATA_WIDTH   = AXI_DATA_W,
  parameter int unsigned C_M_AXI_ADDR_WIDTH   = AXI_ADDR_W
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,

  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     write_data,
  input  logic                              start_read,
  input  logic                              start_write,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,

  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,

  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,

  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY,

  output logic                              done,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     read_data
);

  // The data path is fixed at 32 bits; the clock frequency is descriptive
  // but must at least be a sensible value.
  if (C_M_AXI_DATA_WIDTH != 32 || C_M_AXI_ACLK_FREQ_HZ == 0) begin : g_param_check
    $error("axi_lite_master: C_M_AXI_DATA_WIDTH must be 32 and clock frequency nonzero");
  end

  state_t                          state_q, state_d;
  logic                            aw_done_q, aw_done_d;
  logic                            w_done_q, w_done_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   read_data_q, read_data_d;
  logic                            done_q, done_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Valids and readys are pure decodes of registered state, so they change
  // only at clock edges. Each write valid falls once its own handshake is
  // recorded, independently of the other channel.
  assign M_AXI_AWVALID = (state_q == WR_AW_W) && !aw_done_q;
  assign M_AXI_WVALID  = (state_q == WR_AW_W) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == WR_B);
  assign M_AXI_ARVALID = (state_q == RD_AR);
  assign M_AXI_RREADY  = (state_q == RD_R);

  // A single address register feeds both address channels; only one
  // transaction is ever in flight so they never need different values.
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign done          = done_q;
  assign read_data     = read_data_q;

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
  assign b_hs  = M_AXI_BREADY  && M_AXI_BVALID;
  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs  = M_AXI_RREADY  && M_AXI_RVALID;

  // Next-state logic. Response codes are deliberately not inspected: every
  // B/R handshake completes the transaction the same way.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (start_write) begin
          addr_d  = addr;
          wdata_d = write_data;
          state_d = WR_AW_W;
        end else if (start_read) begin
          addr_d  = addr;
          state_d = RD_AR;
        end
      end

      WR_AW_W: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // Both handshakes may land in the same cycle or in either order.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = WR_B;
        end
      end

      WR_B: begin
        if (b_hs) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      RD_AR: begin
        if (ar_hs) state_d = RD_R;
      end

      RD_R: begin
        if (r_hs) begin
          read_data_d = M_AXI_RDATA;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q     <= IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_master
// Directed and randomized bench for axi_lite_master. A small behavioural
// slave with programmable per-channel wait states answers the master; a
// reference memory and a latency formula provide the expected results.
// ---------------------------------------------------------------------------
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic        startRead;
  logic        startWrite;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        done;
  logic [31:0] readData;

  int errors = 0;
  int checks = 0;

  // Slave behaviour knobs, changed only while the master is idle.
  int         awDelay = 0, wDelay = 0, bDelay = 0, arDelay = 0, rDelay = 0;
  logic [1:0] bRespCfg = 2'b00, rRespCfg = 2'b00;

  // Slave storage (16 words) and the bench's own reference copy.
  logic [31:0] slaveMem [16] = '{default: 32'h0};
  logic [31:0] refMem   [16] = '{default: 32'h0};

  always #5 clk = ~clk;

  axi_lite_master dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESET  (rst),
    .addr          (addr),
    .write_data    (writeData),
    .start_read    (startRead),
    .start_write   (startWrite),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready),
    .done          (done),
    .read_data     (readData)
  );

  // Bus monitor: records handshakes as they happen at the clock edge and
  // commits accepted writes into the slave memory.
  int          doneCount = 0, arValidCycles = 0;
  int          wrAccept = 0, arAccept = 0, bHs = 0, rHs = 0;
  logic        gotAw = 1'b0, gotW = 1'b0;
  logic [31:0] capAwAddr = 32'h0, capWData = 32'h0, capArAddr = 32'h0;
  logic [3:0]  capWStrb = 4'h0;

  always @(posedge clk) begin
    if (done) doneCount++;
    if (arvalid) arValidCycles++;
    if (rst) begin
      gotAw = 1'b0; gotW = 1'b0;
      wrAccept = 0; arAccept = 0; bHs = 0; rHs = 0;
    end else begin
      if (awvalid && awready) begin capAwAddr = awaddr; gotAw = 1'b1; end
      if (wvalid && wready) begin capWData = wdata; capWStrb = wstrb; gotW = 1'b1; end
      if (gotAw && gotW) begin
        slaveMem[capAwAddr[5:2]] = capWData;
        wrAccept++;
        gotAw = 1'b0; gotW = 1'b0;
      end
      if (arvalid && arready) begin capArAddr = araddr; arAccept++; end
      if (bvalid && bready) bHs++;
      if (rvalid && rready) rHs++;
    end
  end

  // Slave responder: drives its outputs on the falling edge. A ready rises
  // after the programmed number of cycles of valid; responses follow each
  // accepted request after their own programmed delay.
  int awWait = 0, wWait = 0, arWait = 0, bWait = 0, rWait = 0;
  int bIssued = 0, rIssued = 0;

  always @(negedge clk) begin
    if (rst) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bvalid = 1'b0; rvalid = 1'b0;
      awWait = 0; wWait = 0; arWait = 0; bWait = 0; rWait = 0;
      bIssued = 0; rIssued = 0;
    end else begin
      if (awvalid) begin
        if (awWait < awDelay) begin awWait++; awready = 1'b0; end else awready = 1'b1;
      end else begin awready = 1'b0; awWait = 0; end

      if (wvalid) begin
        if (wWait < wDelay) begin wWait++; wready = 1'b0; end else wready = 1'b1;
      end else begin wready = 1'b0; wWait = 0; end

      if (arvalid) begin
        if (arWait < arDelay) begin arWait++; arready = 1'b0; end else arready = 1'b1;
      end else begin arready = 1'b0; arWait = 0; end

      if (bvalid && bHs == bIssued) bvalid = 1'b0;
      if (!bvalid && wrAccept > bIssued) begin
        if (bWait < bDelay) bWait++;
        else begin bvalid = 1'b1; bresp = bRespCfg; bIssued++; bWait = 0; end
      end

      if (rvalid && rHs == rIssued) rvalid = 1'b0;
      if (!rvalid && arAccept > rIssued) begin
        if (rWait < rDelay) rWait++;
        else begin
          rvalid = 1'b1; rresp = rRespCfg; rdata = slaveMem[capArAddr[5:2]];
          rIssued++; rWait = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present a request; called on a falling edge so it is sampled next rise.
  task automatic applyStimulus(input logic w, input logic r,
                               input logic [31:0] a, input logic [31:0] d);
    startWrite = w;
    startRead  = r;
    addr       = a;
    writeData  = d;
  endtask

  // Wait for done, counting falling edges since the request; the request
  // pulse is withdrawn after the first edge. An expired bound fails.
  task automatic waitDone(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin startWrite = 1'b0; startRead = 1'b0; end
    end while (!done && cycles < 60);
    checkOutput({tag, "_done_seen"}, {31'b0, done}, 32'h1);
  endtask

  function automatic int writeLatency();
    return ((awDelay > wDelay) ? awDelay : wDelay) + bDelay + 3;
  endfunction

  function automatic int readLatency();
    return arDelay + rDelay + 3;
  endfunction

  task automatic doWrite(input logic [31:0] a, input logic [31:0] d, input string tag);
    int cyc, dc0, expLat;
    expLat = writeLatency();
    dc0 = doneCount;
    applyStimulus(1'b1, 1'b0, a, d);
    waitDone(tag, cyc);
    refMem[a[5:2]] = d;
    checkOutput({tag, "_latency"}, cyc, expLat);
    checkOutput({tag, "_awaddr"}, capAwAddr, a);
    checkOutput({tag, "_wdata"}, capWData, d);
    checkOutput({tag, "_wstrb"}, {28'b0, capWStrb}, 32'hF);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, {31'b0, done}, 32'h0);
    checkOutput({tag, "_done_count"}, doneCount - dc0, 32'd1);
  endtask

  task automatic doRead(input logic [31:0] a, input string tag);
    int cyc, dc0, expLat;
    expLat = readLatency();
    dc0 = doneCount;
    applyStimulus(1'b0, 1'b1, a, 32'h0);
    waitDone(tag, cyc);
    checkOutput({tag, "_latency"}, cyc, expLat);
    checkOutput({tag, "_read_data"}, readData, refMem[a[5:2]]);
    checkOutput({tag, "_araddr"}, capArAddr, a);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, {31'b0, done}, 32'h0);
    checkOutput({tag, "_done_count"}, doneCount - dc0, 32'd1);
    checkOutput({tag, "_read_hold"}, readData, refMem[a[5:2]]);
  endtask

  // Write with one channel lagging; two edges after the request the faster
  // channel's valid has fallen while the slower one is still pending.
  task automatic probeWrite(input logic [31:0] a, input logic [31:0] d, input string tag,
                            input logic expAwValid, input logic expWValid);
    int cyc, dc0, expLat;
    expLat = writeLatency();
    dc0 = doneCount;
    applyStimulus(1'b1, 1'b0, a, d);
    @(negedge clk);
    startWrite = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_valids_mid"}, {30'b0, awvalid, wvalid}, {30'b0, expAwValid, expWValid});
    checkOutput({tag, "_bready_mid"}, {31'b0, bready}, 32'h0);
    checkOutput({tag, "_no_early_done"}, doneCount - dc0, 32'd0);
    waitDone(tag, cyc);
    refMem[a[5:2]] = d;
    checkOutput({tag, "_latency"}, cyc + 2, expLat);
    checkOutput({tag, "_wdata"}, capWData, d);
    @(negedge clk);
    checkOutput({tag, "_done_count"}, doneCount - dc0, 32'd1);
  endtask

  // Fail-safe: the run must always end.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cyc, dc0, arv0, i;
    logic [31:0] a, d, lastRead;

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);

    checkOutput("reset_ctrl", {26'b0, awvalid, wvalid, bready, arvalid, rready, done}, 32'h0);
    checkOutput("reset_read_data", readData, 32'h0);
    checkOutput("reset_awaddr", awaddr, 32'h0);
    checkOutput("reset_araddr", araddr, 32'h0);
    checkOutput("reset_wdata", wdata, 32'h0);
    checkOutput("reset_wstrb", {28'b0, wstrb}, 32'hF);

    rst = 1'b0;
    @(negedge clk);

    $display("[TB] zero-wait writes and reads");
    doWrite(32'h0, 32'hDEADBEEF, "wr0");
    doWrite(32'h4, 32'hABCD0123, "wr4");
    doRead(32'h0, "rd0");
    doRead(32'h4, "rd4");

    $display("[TB] one write channel lagging the other");
    wDelay = 3; bDelay = 2;
    probeWrite(32'h8, 32'h11112222, "w_lag", 1'b0, 1'b1);
    wDelay = 0; awDelay = 3;
    probeWrite(32'hC, 32'h33334444, "aw_lag", 1'b1, 1'b0);
    awDelay = 0; bDelay = 0;

    $display("[TB] simultaneous start: write wins");
    arv0 = arValidCycles;
    dc0 = doneCount;
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h5A5A0F0F);
    waitDone("both", cyc);
    refMem[8] = 32'h5A5A0F0F;
    checkOutput("both_latency", cyc, 32'd3);
    checkOutput("both_awaddr", capAwAddr, 32'h20);
    repeat (3) @(negedge clk);
    checkOutput("both_no_arvalid", arValidCycles - arv0, 32'd0);
    checkOutput("both_done_count", doneCount - dc0, 32'd1);
    doRead(32'h20, "both_readback");

    $display("[TB] read request during a write is ignored");
    bDelay = 3;
    arv0 = arValidCycles;
    dc0 = doneCount;
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0BADF00D);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'h14, 32'h0);
    @(negedge clk);
    startRead = 1'b0;
    waitDone("rd_during_wr", cyc);
    refMem[4] = 32'h0BADF00D;
    repeat (6) @(negedge clk);
    checkOutput("rd_during_wr_done_count", doneCount - dc0, 32'd1);
    checkOutput("rd_during_wr_no_arvalid", arValidCycles - arv0, 32'd0);
    bDelay = 0;

    $display("[TB] start accepted in the done cycle");
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
    waitDone("b2b_rd", cyc);
    checkOutput("b2b_rd_data", readData, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 32'h18, 32'hCAFE1234);
    waitDone("b2b_wr", cyc);
    refMem[6] = 32'hCAFE1234;
    checkOutput("b2b_wr_latency", cyc, 32'd3);
    checkOutput("b2b_wr_awaddr", capAwAddr, 32'h18);
    @(negedge clk);

    $display("[TB] reset while waiting for the write response");
    bDelay = 8;
    dc0 = doneCount;
    applyStimulus(1'b1, 1'b0, 32'h1C, 32'h77778888);
    i = 0;
    do begin
      @(negedge clk);
      startWrite = 1'b0;
      i++;
    end while (!bready && i < 20);
    checkOutput("abort_reached_wr_b", {31'b0, bready}, 32'h1);
    refMem[7] = 32'h77778888;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_bready", {31'b0, bready}, 32'h0);
    checkOutput("abort_valids", {29'b0, awvalid, wvalid, done}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort_no_done", doneCount - dc0, 32'd0);
    bDelay = 0;
    doWrite(32'h1C, 32'h9999AAAA, "after_abort");
    doRead(32'h1C, "after_abort_rd");

    $display("[TB] randomized transactions");
    lastRead = readData;
    for (int n = 0; n < 24; n++) begin
      awDelay  = $urandom_range(0, 3);
      wDelay   = $urandom_range(0, 3);
      bDelay   = $urandom_range(0, 3);
      arDelay  = $urandom_range(0, 3);
      rDelay   = $urandom_range(0, 3);
      bRespCfg = 2'($urandom_range(0, 3));
      rRespCfg = 2'($urandom_range(0, 3));
      a = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        doWrite(a, d, "rand_wr");
        checkOutput("rand_wr_keeps_read_data", readData, lastRead);
      end else begin
        doRead(a, "rand_rd");
        lastRead = refMem[a[5:2]];
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
